// File: rtl/cdc_tx_scheduler.sv
// Source-domain scheduler sharing one data_in/data_en CDC channel between N_REQ requesters.
// Round-robin winner is latched, held with data_en high for HOLD_CYC cycles, then a GAP_CYC quiet gap.
module cdc_tx_scheduler #(
    parameter int N_REQ    = 4,
    parameter int DW       = 4,
    parameter int HOLD_CYC = 4,
    parameter int GAP_CYC  = 2
) (
    input  logic                     clk_a,
    input  logic                     arstn,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DW-1:0]      req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [DW-1:0]            data_in,
    output logic                     data_en,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy
);
    localparam int IW   = $clog2(N_REQ);
    localparam int MAXC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [IW-1:0]    last, last_d, win, grant_id_d;
    logic             win_vld, grant;
    logic [N_REQ-1:0] gnt_d;
    logic [DW-1:0]    data_in_d;

    // Scan from last+1 so the most recent winner has lowest priority.
    always_comb begin
        int j;
        j       = 0;
        win     = '0;
        win_vld = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = int'(last) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!win_vld && req[IW'(j)]) begin
                win_vld = 1'b1;
                win     = IW'(j);
            end
        end
    end

    always_ff @(posedge clk_a or negedge arstn) begin
        if (!arstn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            last     <= IW'(N_REQ - 1);
            gnt      <= '0;
            data_in  <= '0;
            data_en  <= 1'b0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            last     <= last_d;
            gnt      <= gnt_d;
            data_in  <= data_in_d;
            data_en  <= (state_d == S_HOLD);
            grant_id <= grant_id_d;
            busy     <= (state_d != S_IDLE);
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            S_IDLE: if (win_vld) begin
                state_d = S_HOLD;
                cnt_d   = '0;
            end
            S_HOLD: if (cnt == CW'(HOLD_CYC - 1)) begin
                state_d = S_GAP;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt + CW'(1);
            end
            S_GAP: if (cnt == CW'(GAP_CYC - 1)) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt + CW'(1);
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Next values for the registered outputs; the word is captured only at grant.
    always_comb begin
        grant      = (state == S_IDLE) && win_vld;
        gnt_d      = '0;
        data_in_d  = data_in;
        grant_id_d = grant_id;
        last_d     = last;
        if (grant) begin
            gnt_d      = N_REQ'(1) << win;
            data_in_d  = req_data[int'(win)*DW +: DW];
            grant_id_d = win;
            last_d     = win;
        end
    end
endmodule

// File: tb/tb_cdc_tx_scheduler.sv
// Directed bench for cdc_tx_scheduler: default instance plus a HOLD_CYC=1/GAP_CYC=1 instance.
module tb_cdc_tx_scheduler;
    logic        clk = 1'b0;
    logic        arstn;
    logic [3:0]  req, req6;
    logic [15:0] req_data, req_data6;
    logic [3:0]  gnt, gnt6;
    logic [3:0]  data_in, data_in6;
    logic        data_en, data_en6;
    logic [1:0]  grant_id, grant_id6;
    logic        busy, busy6;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    cdc_tx_scheduler #(.N_REQ(4), .DW(4), .HOLD_CYC(4), .GAP_CYC(2)) dut (
        .clk_a(clk), .arstn(arstn), .req(req), .req_data(req_data), .gnt(gnt),
        .data_in(data_in), .data_en(data_en), .grant_id(grant_id), .busy(busy));

    cdc_tx_scheduler #(.N_REQ(4), .DW(4), .HOLD_CYC(1), .GAP_CYC(1)) dut6 (
        .clk_a(clk), .arstn(arstn), .req(req6), .req_data(req_data6), .gnt(gnt6),
        .data_in(data_in6), .data_en(data_en6), .grant_id(grant_id6), .busy(busy6));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arstn = 1'b0; req = '0; req6 = '0; req_data = '0; req_data6 = '0;
        #1;
        checks++;
        if ({gnt, data_in, data_en, grant_id, busy} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got gnt=%b din=%h en=%b id=%0d busy=%b exp all zero",
                     gnt, data_in, data_en, grant_id, busy);
        end
        step(); step();
        arstn = 1'b1;
        step();
        checks++;
        if (data_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got en=%b busy=%b exp 0 0", data_en, busy);
        end
    endtask

    task automatic test_single();
        req = 4'b0010; req_data = 16'h00A0;
        step();
        checks++;
        if (gnt !== 4'b0010 || data_in !== 4'hA || data_en !== 1'b1 || busy !== 1'b1 || grant_id !== 2'd1) begin
            failures++;
            $display("FAIL single_grant got gnt=%b din=%h en=%b busy=%b id=%0d exp 0010 a 1 1 1",
                     gnt, data_in, data_en, busy, grant_id);
        end
        req = '0; req_data = 16'h0050;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (data_en !== 1'b1 || gnt !== 4'b0000 || data_in !== 4'hA) begin
                failures++;
                $display("FAIL single_hold%0d got en=%b gnt=%b din=%h exp 1 0000 a", k, data_en, gnt, data_in);
            end
        end
        for (int k = 4; k <= 5; k++) begin
            step();
            checks++;
            if (data_en !== 1'b0 || busy !== 1'b1 || data_in !== 4'hA) begin
                failures++;
                $display("FAIL single_gap%0d got en=%b busy=%b din=%h exp 0 1 a", k, data_en, busy, data_in);
            end
        end
        step();
        checks++;
        if (busy !== 1'b0 || data_en !== 1'b0 || data_in !== 4'hA) begin
            failures++;
            $display("FAIL single_done got busy=%b en=%b din=%h exp 0 0 a", busy, data_en, data_in);
        end
    endtask

    // Last grant went to requester 1, so 3 must beat 0.
    task automatic test_rr_skip();
        req = 4'b1001; req_data = 16'h7006;
        step();
        checks++;
        if (gnt !== 4'b1000 || data_in !== 4'h7 || grant_id !== 2'd3) begin
            failures++;
            $display("FAIL rr_skip_first got gnt=%b din=%h id=%0d exp 1000 7 3", gnt, data_in, grant_id);
        end
        req = 4'b0001;
        repeat (6) step();
        step();
        checks++;
        if (gnt !== 4'b0001 || data_in !== 4'h6 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL rr_skip_second got gnt=%b din=%h id=%0d exp 0001 6 0", gnt, data_in, grant_id);
        end
        req = '0;
        repeat (6) step();
    endtask

    task automatic test_saturation();
        arstn = 1'b0;
        #1;
        step();
        arstn = 1'b1;
        req = 4'b1111; req_data = 16'hDCBA;
        for (int g = 0; g < 5; g++) begin
            logic [3:0] exp_gnt;
            logic [3:0] exp_word;
            exp_gnt  = 4'b0001 << (g % 4);
            exp_word = 4'hA + 4'(g % 4);
            step();
            checks++;
            if (gnt !== exp_gnt || data_in !== exp_word || data_en !== 1'b1 || grant_id !== 2'(g % 4)) begin
                failures++;
                $display("FAIL sat_grant%0d got gnt=%b din=%h en=%b id=%0d exp %b %h 1 %0d",
                         g, gnt, data_in, data_en, grant_id, exp_gnt, exp_word, g % 4);
            end
            repeat (6) step();
            checks++;
            if (data_en !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL sat_gap%0d got en=%b busy=%b exp 0 0", g, data_en, busy);
            end
        end
        req = '0;
    endtask

    task automatic test_withdraw();
        logic seen;
        req = 4'b0001; req_data = 16'h0903;
        step();
        checks++;
        if (gnt !== 4'b0001 || data_in !== 4'h3) begin
            failures++;
            $display("FAIL wd_first got gnt=%b din=%h exp 0001 3", gnt, data_in);
        end
        req = '0;
        seen = 1'b0;
        step();
        req = 4'b0100;
        step(); step();
        req = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            seen = seen | (gnt != 4'b0000);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wd_idle got busy=%b exp 0", busy);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            seen = seen | data_en | (gnt != 4'b0000);
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL wd_no_grant got activity=%b exp 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        req = 4'b0100; req_data = 16'hDCBA;
        step();
        checks++;
        if (gnt !== 4'b0100 || data_in !== 4'hC) begin
            failures++;
            $display("FAIL rst_pre_grant got gnt=%b din=%h exp 0100 c", gnt, data_in);
        end
        req = '0;
        step();
        #2;
        arstn = 1'b0;
        #1;
        checks++;
        if (data_en !== 1'b0 || data_in !== 4'h0 || busy !== 1'b0 || gnt !== 4'b0000) begin
            failures++;
            $display("FAIL rst_async got en=%b din=%h busy=%b gnt=%b exp 0 0 0 0000", data_en, data_in, busy, gnt);
        end
        req = 4'b1111;
        step();
        arstn = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0001 || data_in !== 4'hA || data_en !== 1'b1) begin
            failures++;
            $display("FAIL rst_first_grant got gnt=%b din=%h en=%b exp 0001 a 1", gnt, data_in, data_en);
        end
        req = '0;
        repeat (6) step();
    endtask

    task automatic test_short();
        req6 = 4'b0001; req_data6 = 16'h0005;
        for (int k = 0; k < 9; k++) begin
            logic exp;
            exp = (k % 3 == 0);
            step();
            checks++;
            if (data_en6 !== exp || gnt6[0] !== exp) begin
                failures++;
                $display("FAIL short_pat%0d got en=%b gnt0=%b exp %b", k, data_en6, gnt6[0], exp);
            end
        end
        checks++;
        if (data_in6 !== 4'h5) begin
            failures++;
            $display("FAIL short_word got din=%h exp 5", data_in6);
        end
        req6 = '0;
        repeat (3) step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_skip();
        test_saturation();
        test_withdraw();
        test_reset_mid();
        test_short();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
